div_core: RTL and testbench
===========================

# div_core

Multi-cycle 32-bit radix-2 restoring divider for the EX stage. It receives the `divstart`/signed-select handshake from the EX-stage divide decoder and computes DIV/DIVU. It returns `ready` for exactly one cycle together with `{remainder, quotient}`, which is written to HI/LO. The pipeline stalls while `start` is high and `ready` is low.

## Interface
Parameters:
- `WIDTH`, 32, operand width. Only 32 is supported and verified.

Ports:
- `clk`, input, 1: rising-edge clock.
- `resetn`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a division. Sampled only in IDLE.
- `signed_div`, input, 1: 1 = DIV, 0 = DIVU. Sampled with `start`.
- `opdata1`, input, 32: dividend (rs). Sampled with `start`.
- `opdata2`, input, 32: divisor (rt). Sampled with `start`.
- `annul`, input, 1: flush (exception or eret). Aborts any operation in progress.
- `ready`, output, 1: result valid. High for one cycle per completed operation.
- `result`, output, 64: `{hi = remainder, lo = quotient}`.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: iterating. Holds a 6-bit counter.
  - DONE: `ready` = 1.
- IDLE → BUSY when `start` && !`annul`. On that edge the block latches:
  - |opdata1| and |opdata2| (absolute values taken only when `signed_div`);
  - the quotient sign `s_q` = `signed_div` & (a[31] ^ b[31]);
  - the remainder sign `s_r` = `signed_div` & a[31].
- Operand changes after the sampling edge are ignored.
- BUSY, one restoring step per cycle:
  - rem = {rem[31:0], dividend_msb}; dividend shifts left by 1.
  - If rem ≥ divisor: rem -= divisor and the q bit is 1. Otherwise the q bit is 0.
  - rem is 33 bits wide so no overflow occurs.
  - After 32 steps: state → DONE and `result` is loaded with the sign-corrected values (two's-complement negation where `s_q` or `s_r` is set).
- DONE → IDLE unconditionally on the next edge.
  - A `start` seen while in DONE is ignored. The decoder drops `start` in the cycle after `ready`.
  - A back-to-back divide is accepted from IDLE.
- Arithmetic corner cases:
  - 0x80000000 / 0xFFFFFFFF (signed): lo = 0x80000000, hi = 0.
  - Divisor 0, which is architecturally undefined: hi = opdata1, and lo = 32'h0000_0001 if `signed_div` && opdata1[31], else 32'hFFFF_FFFF. These are the natural restoring-divider results and must match in both build modes.
- `annul`:
  - In BUSY or DONE: next state is IDLE, `ready` is forced to 0 that cycle, and `result` is not updated.
  - `annul` has priority over `start`.
- `result` holds its last value until the next completion.

## Timing
- Reset values: state = IDLE, `ready` = 0, `result` = 64'h0, counter = 0. Reset mid-operation discards the operation.
- `ready` is a registered-state decode (state == DONE), with no combinational path from inputs, except that `annul` masks it combinationally.
- Latency: `start` sampled at edge E0 → BUSY for edges E1..E32 → `ready` high in the cycle after E32, i.e. 33 cycles after the request cycle.
- Throughput: one divide per 34 cycles (request, 32 iterations, DONE). The next `start` is accepted in the IDLE cycle after DONE.
- With `DIV_EARLY_OUT_EN`, shortcut cases show `ready` in the cycle after E1, a latency of 2.

## Configuration
- `DIV_EARLY_OUT_EN`: defined means that on the sampling edge, if the divisor is 0 or |dividend| < |divisor|, the block goes through one BUSY cycle that loads `result` directly, then DONE.
  - Divisor 0: loads the corner-case values above.
  - Small dividend: hi = opdata1, lo = 0.
- Not defined: every operation takes the full 33-cycle latency.
- Results must be bit-identical in both modes.

## Structure
- Shared header `defines.vh`:
  - state encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`;
  - `DIV_STEPS` = 32.
  - The existing `DIV_CONTROL`/`DIVU_CONTROL` definitions are not touched.
- Sub-module `div_step`: combinational single restoring step, 33-bit rem / 32-bit divisor in, next rem and q bit out. It is instantiated once and the top-level FSM iterates on it.

## Test plan
- Unsigned: 100 / 7, `signed_div` = 0 → `ready` at cycle 33, `result` = {32'd2, 32'd14}.
- Signed: -7 / 2 → hi = 0xFFFFFFFF (-1), lo = 0xFFFFFFFD (-3). Signed 7 / -2 → hi = 1, lo = 0xFFFFFFFD.
- Overflow and zero divisor:
  - 0x80000000 / 0xFFFFFFFF signed → {0, 0x80000000}.
  - 0xFFFFFFF0 / 0 signed → {0xFFFFFFF0, 0x00000001}.
  - Latency is 33, or 2 with `DIV_EARLY_OUT_EN`.
- Back-to-back: a second `start` (50 / 5) in the IDLE cycle after `ready` → second `ready` exactly 34 cycles after the first, `result` = {0, 10}. `ready` is never high for two consecutive cycles.
- `annul` at iteration 10, then a new `start` with 9 / 3 → no `ready` for the aborted operation, `result` unchanged until the new completion yields {0, 3}.
- `resetn` low at iteration 20 → `ready` = 0 and `result` = 0 immediately (asynchronous). After release, a divide from IDLE completes normally.

Source files
------------

// File: rtl/div_core_pkg.sv
// Shared definitions for the div_core radix-2 restoring divider: FSM state
// encodings, iteration count and the conditional two's-complement helper.
package div_core_pkg;

  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: trial-subtract the divisor from
// the 33-bit partial remainder and keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_diff;

  // i_rem < 2*divisor, so a non-negative difference always fits in WIDTH bits
  assign w_diff = i_rem - {1'b0, i_divisor};
  assign o_q    = ~w_diff[WIDTH];
  assign o_rem  = o_q ? w_diff[WIDTH-1:0] : i_rem[WIDTH-1:0];

endmodule

// File: rtl/div_core.sv
// Multi-cycle 32-bit DIV/DIVU unit for the EX stage, result = {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and |a| < |b| after one BUSY cycle.
module div_core
  import div_core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  div_state_e         r_state;
  div_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic               r_sq;
  logic               r_sr;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_step_rem;
  logic               w_step_q;
  logic [WIDTH-1:0]   w_quo_fin;
  logic [WIDTH-1:0]   w_rem_fin;
  logic               w_busy;
  logic               w_accept;
  logic               w_last;
  logic               w_finish;

  assign w_abs_a  = cond_neg(opdata1, signed_div & opdata1[WIDTH-1]);
  assign w_abs_b  = cond_neg(opdata2, signed_div & opdata2[WIDTH-1]);
  assign w_busy   = (r_state == DIV_BUSY);
  assign w_accept = (r_state == DIV_IDLE) && start && !annul;
  assign w_finish = w_last && !annul;

  // The dividend register doubles as the quotient: q bits enter at the LSB
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     ({r_rem, r_dvd[WIDTH-1]}),
    .i_divisor (r_dvs),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

`ifdef DIV_EARLY_OUT_EN
  logic r_early;
  logic w_early;

  assign w_early   = (opdata2 == '0) || (w_abs_a < w_abs_b);
  assign w_last    = w_busy && (r_early || (r_cnt == CNT_W'(DIV_STEPS - 1)));
  // Shortcut results equal what 32 restoring steps would produce
  assign w_quo_fin = r_early ? {WIDTH{r_dvs == '0}} : {r_dvd[WIDTH-2:0], w_step_q};
  assign w_rem_fin = r_early ? r_dvd : w_step_rem;
`else
  assign w_last    = w_busy && (r_cnt == CNT_W'(DIV_STEPS - 1));
  assign w_quo_fin = {r_dvd[WIDTH-2:0], w_step_q};
  assign w_rem_fin = w_step_rem;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (start && !annul) w_state_nxt = DIV_BUSY;
      DIV_BUSY: begin
        if (annul)       w_state_nxt = DIV_IDLE;
        else if (w_last) w_state_nxt = DIV_DONE;
      end
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == DIV_DONE) && !annul;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_finish) begin
        r_result <= {cond_neg(w_rem_fin, r_sr), cond_neg(w_quo_fin, r_sq)};
      end
    end
  end

  // Operand datapath; only meaningful after an accepted request
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dvd <= w_abs_a;
      r_dvs <= w_abs_b;
      r_rem <= '0;
      r_sq  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
      r_sr  <= signed_div & opdata1[WIDTH-1];
`ifdef DIV_EARLY_OUT_EN
      r_early <= w_early;
`endif
    end else if (w_busy) begin
      r_dvd <= {r_dvd[WIDTH-2:0], w_step_q};
      r_rem <= w_step_rem;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_div_core.sv
// Self-checking bench for div_core: directed vector table, multi-cycle corner
// sequences (back-to-back, annul, async reset) and randomized model checks.
module tb_div_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        ready;
  logic [63:0] result;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   viol = 0;
  logic prev_rdy = 1'b0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  div_core #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready && prev_rdy) viol++;
    prev_rdy <= ready;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    bit          shortcut;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Architectural reference: truncating division, zero divisor per the ISA rule
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint q;
    longint r;
    logic [31:0] hi;
    logic [31:0] lo;
    if (b == 32'd0) begin
      hi = a;
      lo = (s && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
    end else if (s) begin
      q  = longint'($signed(a)) / longint'($signed(b));
      r  = longint'($signed(a)) % longint'($signed(b));
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      q  = longint'(a) / longint'(b);
      r  = longint'(a) % longint'(b);
      lo = q[31:0];
      hi = r[31:0];
    end
    return {hi, lo};
  endfunction

  function automatic bit model_short(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ma;
    longint mb;
    ma = (s && a[31]) ? -longint'($signed(a)) : longint'(a);
    mb = (s && b[31]) ? -longint'($signed(b)) : longint'(b);
    return (b == 32'd0) || (ma < mb);
  endfunction

  // Issues one request and waits for ready; lat counts cycles from the request cycle
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] res, output int lat, output int t);
    res = '0;
    lat = -1;
    t   = 0;
    @(posedge clk);
    #1;
    start      = 1'b1;
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        opdata1 = ~a;
        opdata2 = b ^ 32'h0000_0005;
      end
      if (ready) begin
        lat   = k;
        res   = result;
        t     = cyc;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] res1;
    int          lat;
    int          lat1;
    int          t1;
    int          t2;
    int          rdy_cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    tbl[0] = '{"u100_7",     32'd100,       32'd7,         1'b0, {32'd2, 32'd14},                       1'b0};
    tbl[1] = '{"s_m7_2",     32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD},        1'b0};
    tbl[2] = '{"s_7_m2",     32'd7,         32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD},                1'b0};
    tbl[3] = '{"s_ovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000},                1'b0};
    tbl[4] = '{"s_div0",     32'hFFFF_FFF0, 32'd0,         1'b1, {32'hFFFF_FFF0, 32'h0000_0001},        1'b1};
    tbl[5] = '{"u_div0",     32'hFFFF_FFF0, 32'd0,         1'b0, {32'hFFFF_FFF0, 32'hFFFF_FFFF},        1'b1};
    tbl[6] = '{"u_small",    32'd5,         32'd100,       1'b0, {32'd5, 32'd0},                        1'b1};
    tbl[7] = '{"s_small",    32'hFFFF_FFFB, 32'd100,       1'b1, {32'hFFFF_FFFB, 32'd0},                1'b1};

    #3 resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      run_div(tbl[i].a, tbl[i].b, tbl[i].s, res, lat, t1);
      check(tbl[i].name, res, tbl[i].exp);
      check({tbl[i].name, "_lat"}, 64'(lat), (tbl[i].shortcut && EARLY) ? 64'd2 : 64'd33);
    end

    // back-to-back: second request in the IDLE cycle right after ready
    run_div(32'd100, 32'd7, 1'b0, res1, lat1, t1);
    run_div(32'd50, 32'd5, 1'b0, res, lat, t2);
    check("b2b_first", res1, {32'd2, 32'd14});
    check("b2b_second", res, {32'd0, 32'd10});
    check("b2b_gap", 64'(t2 - t1), 64'd34);

    // annul after ten iterations
    @(posedge clk);
    #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    check("annul_noready", 64'(rdy_cnt), 64'd0);
    check("annul_hold", result, {32'd0, 32'd10});
    run_div(32'd9, 32'd3, 1'b0, res, lat, t1);
    check("annul_next", res, {32'd0, 32'd3});
    check("annul_next_lat", 64'(lat), 64'd33);

    // asynchronous reset at iteration twenty
    @(posedge clk);
    #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd7;
    repeat (21) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_result", result, 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_div(32'd100, 32'd7, 1'b0, res, lat, t1);
    check("rst_after", res, {32'd2, 32'd14});
    check("rst_after_lat", 64'(lat), 64'd33);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(0, 15));
        2: rb = 32'd0;
        default: begin
          rb = $urandom;
          ra = 32'($urandom_range(0, 255));
        end
      endcase
      if (n == 0) begin ra = 32'h8000_0000; rb = 32'd1; rs = 1'b1; end
      run_div(ra, rb, rs, res, lat, t1);
      check($sformatf("rnd%0d_%h_%h_%0d", n, ra, rb, rs), res, model(ra, rb, rs));
      check($sformatf("rnd%0d_lat", n), 64'(lat),
            (EARLY && model_short(ra, rb, rs)) ? 64'd2 : 64'd33);
    end

    check("no_double_ready", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
